// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide with architectural HI/LO.
//   MULTU: radix-2 shift-add, one multiplier bit per cycle (LSB first).
//   DIVU : restoring division, one quotient bit per cycle (MSB first).
//   An operation occupies WIDTH busy cycles; HI/LO are written on the last
//   busy edge and done pulses in the following cycle.
// Optional feature macro: MULDIV_MTHI_MTLO_EN adds mthi_we/mtlo_we/wdata
//   for direct HI/LO writes while the unit is idle or in its done cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_multu,
  input  logic             start_divu,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_MTHI_MTLO_EN
  ,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic               op_div;

  // multiply datapath: multiplicand shifts left, multiplier shifts right
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;

  // divide datapath: dividend bits shift out of quo as quotient bits shift in
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH:0]     rem;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               q_bit;

  logic               start_any;
  logic               accept;
  logic               last;

  assign start_any = start_multu | start_divu;
  assign accept    = (state != S_BUSY) && start_any;
  assign last      = (state == S_BUSY) && (count == CNT_W'(WIDTH - 1));

  // status outputs decode the state register only, so they never see start
  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

  // next-state: BUSY for WIDTH iterations, one DONE cycle, restart allowed in DONE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_any) state_next = S_BUSY;
      S_BUSY:  if (last)      state_next = S_DONE;
      S_DONE:  state_next = start_any ? S_BUSY : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // one iteration of each algorithm; only the one selected by op_div is used
  always_comb begin
    acc_step  = mplier[0] ? (acc + mcand) : acc;
    rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    // a clear top bit means the trial subtraction did not go negative
    q_bit     = ~rem_diff[WIDTH];
    rem_step  = q_bit ? rem_diff : rem_shift;
    quo_step  = {quo[WIDTH-2:0], q_bit};
  end

  // state register and iteration counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (accept)
        count <= '0;
      else if (state == S_BUSY)
        count <= count + CNT_W'(1);
    end
  end

  // operand capture on accept, then one step per busy cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_div  <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
    end else if (accept) begin
      // MULTU takes priority when both strobes are high
      op_div  <= ~start_multu;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      acc     <= '0;
      divisor <= b;
      quo     <= a;
      rem     <= '0;
    end else if (state == S_BUSY) begin
      if (op_div) begin
        rem <= rem_step;
        quo <= quo_step;
      end else begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  // HI/LO: written from the final iteration's result, else hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (last) begin
      if (op_div) begin
        hi <= rem_step[WIDTH-1:0];
        lo <= quo_step;
      end else begin
        hi <= acc_step[2*WIDTH-1:WIDTH];
        lo <= acc_step[WIDTH-1:0];
      end
    end
`ifdef MULDIV_MTHI_MTLO_EN
    // direct writes only when not busy; a simultaneous start drops them
    else if ((state != S_BUSY) && !start_any) begin
      if (mthi_we) hi <= wdata;
      if (mtlo_we) lo <= wdata;
    end
`endif
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// plain-arithmetic reference (64-bit product, / and %, divide-by-zero rule).
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int TMO = 40;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_multu = 1'b0;
  logic         start_divu = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;
`ifdef MULDIV_MTHI_MTLO_EN
  logic         mthi_we = 1'b0;
  logic         mtlo_we = 1'b0;
  logic [W-1:0] wdata = '0;
`endif

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .start_multu(start_multu), .start_divu(start_divu),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_MTHI_MTLO_EN
    , .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata)
`endif
  );

  always #5 clock = ~clock;

  function automatic void model(input bit is_div, input logic [W-1:0] x,
                                input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    logic [2*W-1:0] p;
    if (is_div) begin
      if (y == 0) begin l = '1; h = x; end
      else begin l = x / y; h = x % y; end
    end else begin
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      h = p[2*W-1:W];
      l = p[W-1:0];
    end
  endfunction

  // drive a one-cycle start from a negedge; returns at the negedge of busy cycle 1
  task automatic issue(input bit is_div, input logic [W-1:0] x, input logic [W-1:0] y);
    start_multu = !is_div;
    start_divu  = is_div;
    a = x;
    b = y;
    @(negedge clock);
    start_multu = 1'b0;
    start_divu  = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // advance until done is seen; n is the number of cycles waited (TMO on timeout)
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < TMO) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_multu_max();
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c <= W; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
        errors++;
        $display("FAIL multu_busy_cycle%0d got busy=%b done=%b hi=%h lo=%h want 1 0 0 0", c, busy, done, hi, lo);
      end
      @(negedge clock);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_max_result got busy=%b done=%b hi=%h lo=%h want 0 1 fffffffe 00000001", busy, done, hi, lo);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_divu_back_to_back();
    int n;
    issue(1, 100, 7);
    wait_done(n);
    checks++;
    if (n != W || hi !== 2 || lo !== 14) begin
      errors++;
      $display("FAIL divu_100_7 got wait=%0d hi=%0d lo=%0d want %0d 2 14", n, hi, lo, W);
    end
    issue(0, 3, 5);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(n);
    checks++;
    if (n != W || hi !== 0 || lo !== 15) begin
      errors++;
      $display("FAIL b2b_multu_3_5 got wait=%0d hi=%0d lo=%0d want %0d 0 15", n, hi, lo, W);
    end
    @(negedge clock);
  endtask

  task automatic test_div_zero();
    int n;
    issue(1, 32'h0000_1234, 0);
    wait_done(n);
    checks++;
    if (n != W || hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF || $isunknown({busy, done, hi, lo})) begin
      errors++;
      $display("FAIL divu_by_zero got wait=%0d hi=%h lo=%h want %0d 00001234 ffffffff", n, hi, lo, W);
    end
    @(negedge clock);
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [W-1:0] rh = 'x, rl = 'x;
    issue(0, 6, 7);
    for (int c = 1; c < 10; c++) begin
      a = $urandom; b = $urandom;
      @(negedge clock);
    end
    start_divu = 1'b1;
    a = 32'd100; b = 32'd3;
    @(negedge clock);
    start_divu = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      if (done === 1'b1) begin
        pulses++;
        rh = hi; rl = lo;
      end
      a = $urandom; b = $urandom;
      @(negedge clock);
    end
    checks++;
    if (pulses != 1 || rh !== 0 || rl !== 42) begin
      errors++;
      $display("FAIL ignore_start_in_busy got pulses=%0d hi=%0d lo=%0d want 1 0 42", pulses, rh, rl);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses = 0;
    issue(0, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int c = 1; c < 20; c++) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL reset_mid_op got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < TMO; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
      @(negedge clock);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_done got active_cycles=%0d want 0", pulses);
    end
    issue(0, 9, 9);
    wait_done(n);
    checks++;
    if (n != W || hi !== 0 || lo !== 81) begin
      errors++;
      $display("FAIL after_reset_multu got wait=%0d hi=%0d lo=%0d want %0d 0 81", n, hi, lo, W);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    int n;
    bit is_div;
    logic [W-1:0] x, y, eh, el;
    for (int k = 0; k < 60; k++) begin
      is_div = $urandom_range(0, 1);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = $urandom_range(1, 15);
        2: x = '1;
        3: x = $urandom_range(0, 255);
        default: ;
      endcase
      model(is_div, x, y, eh, el);
      // half the time start from IDLE, otherwise straight from the DONE cycle
      if (k == 0 || $urandom_range(0, 1) == 1) begin
        @(negedge clock);
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      issue(is_div, x, y);
      wait_done(n);
      checks++;
      if (n != W || hi !== eh || lo !== el) begin
        errors++;
        $display("FAIL random_%s_%0d a=%h b=%h got wait=%0d hi=%h lo=%h want %0d %h %h",
                 is_div ? "divu" : "multu", k, x, y, n, hi, lo, W, eh, el);
      end
    end
    @(negedge clock);
  endtask

`ifdef MULDIV_MTHI_MTLO_EN
  task automatic test_mthi_mtlo();
    int n;
    logic [W-1:0] lo0;
    lo0 = lo;
    mthi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    mthi_we = 1'b0;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== lo0) begin
      errors++;
      $display("FAIL mthi_idle got hi=%h lo=%h want deadbeef %h", hi, lo, lo0);
    end
    mtlo_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clock);
    mtlo_we = 1'b0;
    checks++;
    if (lo !== 32'h0BAD_F00D || hi !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mtlo_idle got hi=%h lo=%h want deadbeef 0badf00d", hi, lo);
    end
    // start and write in the same cycle: the write is dropped
    mtlo_we = 1'b1; wdata = 32'h5555_5555;
    issue(0, 2, 3);
    checks++;
    if (lo !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL mtlo_with_start got lo=%h want 0badf00d", lo);
    end
    for (int c = 1; c < 10; c++) @(negedge clock);
    mtlo_we = 1'b0;
    checks++;
    if (lo !== 32'h0BAD_F00D || hi !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mtlo_during_busy got hi=%h lo=%h want deadbeef 0badf00d", hi, lo);
    end
    wait_done(n);
    checks++;
    if (hi !== 0 || lo !== 6) begin
      errors++;
      $display("FAIL mt_then_multu got hi=%h lo=%h want 0 6", hi, lo);
    end
    @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_multu_max();
    test_divu_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_random();
`ifdef MULDIV_MTHI_MTLO_EN
    test_mthi_mtlo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It receives MULTU/DIVU start strobes and rs/rt operands from the execute stage, computes over WIDTH cycles, and holds results in HI/LO for MFHI/MFLO. While busy it stalls the pipeline so later MFHI/MFLO never read stale data.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start_multu  input  1  one-cycle request: HI:LO = a * b.
- start_divu  input  1  one-cycle request: LO = a / b, HI = a % b.
- a  input  WIDTH  rs operand; sampled only on an accepted start.
- b  input  WIDTH  rt operand; sampled only on an accepted start.
- busy  output  1  operation in progress; feeds the hazard unit as a stall.
- done  output  1  one-cycle pulse in the cycle after HI/LO update.
- hi  output  WIDTH  HI register; MFHI data.
- lo  output  WIDTH  LO register; MFLO data.
- mthi_we, mtlo_we, wdata  input  1/1/WIDTH  present only with MULDIV_MTHI_MTLO_EN.

## Operation
- FSM states:
  - IDLE -> BUSY on an accepted start.
  - BUSY runs a count of 0..WIDTH-1 and moves to DONE after the last iteration.
  - DONE -> IDLE, or DONE -> BUSY if a start arrives in DONE.
- A start is accepted only in IDLE or DONE. Starts during BUSY are ignored: no state change and no operand capture.
- If start_multu and start_divu are both high, MULTU wins.
- At acceptance, a and b are latched into internal registers. Later changes on a/b have no effect.
- MULTU uses radix-2 shift-add with a 2*WIDTH product accumulator, one multiplier bit per cycle, LSB first.
  - Result: HI = product[2W-1:W], LO = product[W-1:0].
- DIVU uses restoring division with a WIDTH+1-bit partial remainder, one quotient bit per cycle, MSB first.
  - Result: LO = quotient, HI = remainder.
- Divide by zero: no trap. The algorithm's natural result is required: LO = all ones, HI = a.
- HI/LO are written only on the final BUSY edge. During BUSY, hi/lo keep their previous values.
- Reset: state IDLE, count 0, busy 0, done 0, hi 0, lo 0, internal accumulators 0.
- Reset mid-operation aborts the operation. No HI/LO update and no done pulse occur.

## Timing
- Cycle 0: start is sampled at edge E0.
- Cycles 1..WIDTH: busy = 1.
- At edge E_WIDTH: HI/LO are updated.
- Cycle WIDTH+1: busy = 0 and done = 1 for exactly one cycle. hi/lo already show the new result.
- Total latency from start to valid HI/LO is WIDTH+1 cycles (33 at WIDTH = 32).
- Back-to-back: a start in the DONE cycle is accepted, so busy is high again from the next cycle. Sustained throughput is one operation per WIDTH+1 cycles.
- busy and done are registered outputs with no combinational path from the start inputs.

## Configuration
- MULDIV_MTHI_MTLO_EN defined:
  - Adds ports mthi_we, mtlo_we and wdata.
  - In IDLE or DONE, a write enable loads wdata into HI/LO at the next edge.
  - If a write enable and a start occur in the same cycle, the start wins and the write is dropped.
  - Write enables are ignored during BUSY.
- MULDIV_MTHI_MTLO_EN undefined: these ports do not exist, and HI/LO change only on operation completion or reset.

## Test plan
- MULTU with a = 32'hFFFF_FFFF, b = 32'hFFFF_FFFF -> busy for 32 cycles; done in cycle 33; hi = 32'hFFFF_FFFE, lo = 32'h0000_0001.
- DIVU with a = 100, b = 7 -> lo = 14, hi = 2. A follow-up MULTU issued in the DONE cycle (a = 3, b = 5) -> accepted with no idle gap; hi = 0, lo = 15.
- DIVU with a = 32'h0000_1234, b = 0 -> lo = 32'hFFFF_FFFF, hi = 32'h0000_1234; no X on any output.
- MULTU (6 * 7), then start_divu pulsed at busy cycle 10 with a/b toggled every cycle -> DIVU ignored; result lo = 42, hi = 0; exactly one done pulse.
- reset_n low at busy cycle 20 of MULTU (after a prior result of lo = 42) -> hi = lo = 0, busy = 0 immediately; no done pulse; a new start after release completes normally.
- With MULDIV_MTHI_MTLO_EN: mthi_we with wdata = 32'hDEAD_BEEF in IDLE -> hi = 32'hDEAD_BEEF next cycle. mtlo_we during BUSY -> lo unchanged.
